tcp_slow_path_send_q: RTL and testbench

TCP_SLOW_PATH_SEND_Q -- requirements
Module: tcp_slow_path_send_q

---
 rtl/tcp_slow_path_send_q_pkg.sv | 31 +++
 rtl/slow_path_send_q_mem.sv | 22 ++
 rtl/tcp_slow_path_send_q.sv | 109 ++++++++++
 tb/tb_tcp_slow_path_send_q.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tcp_slow_path_send_q_pkg.sv
// rtl/tcp_slow_path_send_q_pkg.sv - header, flow and slow-path send entry types
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package packet_struct_pkg;
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_pkt_hdr;
endpackage

package tcp_pkg;
    localparam int FLOWID_W = 8;
endpackage

package tcp_misc_pkg;
    import packet_struct_pkg::*;
    import tcp_pkg::*;

    typedef struct packed {
        tcp_pkt_hdr              pkt;
        logic [FLOWID_W-1:0]     flowid;
        logic [`IP_ADDR_W-1:0]   src_ip;
        logic [`IP_ADDR_W-1:0]   dst_ip;
    } slow_path_send_entry_struct;
endpackage

// File: rtl/slow_path_send_q_mem.sv
// rtl/slow_path_send_q_mem.sv - flop array, one write port, one asynchronous read port
module slow_path_send_q_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/tcp_slow_path_send_q.sv
// rtl/tcp_slow_path_send_q.sv - FWFT slow-path send queue; SLOW_PATH_SEND_Q_STATS_EN adds stall_cnt/hwm
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

module tcp_slow_path_send_q
    import packet_struct_pkg::*;
    import tcp_pkg::*;
    import tcp_misc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        slow_path_send_pkt_enqueue_val,
    output logic                        slow_path_send_pkt_enqueue_rdy,
    input  tcp_pkt_hdr                  slow_path_send_pkt_enqueue_pkt,
    input  logic [FLOWID_W-1:0]         slow_path_send_pkt_enqueue_flowid,
    input  logic [`IP_ADDR_W-1:0]       slow_path_send_pkt_enqueue_src_ip,
    input  logic [`IP_ADDR_W-1:0]       slow_path_send_pkt_enqueue_dst_ip,
    output logic                        slow_path_send_q_tx_val,
    input  logic                        tx_slow_path_send_q_rdy,
    output slow_path_send_entry_struct  slow_path_send_q_tx_entry,
    output logic [$clog2(DEPTH):0]      slow_path_send_q_occupancy
`ifdef SLOW_PATH_SEND_Q_STATS_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [$clog2(DEPTH):0]      hwm
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W:0]             occ;
    logic [PTR_W:0]             occ_next;
    logic                       enq_fire;
    logic                       deq_fire;
    slow_path_send_entry_struct wr_entry;

    // Ready and valid depend only on registered occupancy, so there is no bypass path.
    assign slow_path_send_pkt_enqueue_rdy = (occ < FULL_CNT);
    assign slow_path_send_q_tx_val        = (occ != '0);
    assign slow_path_send_q_occupancy     = occ;

    assign enq_fire = slow_path_send_pkt_enqueue_val & slow_path_send_pkt_enqueue_rdy;
    assign deq_fire = slow_path_send_q_tx_val & tx_slow_path_send_q_rdy;

    assign wr_entry = '{pkt:    slow_path_send_pkt_enqueue_pkt,
                        flowid: slow_path_send_pkt_enqueue_flowid,
                        src_ip: slow_path_send_pkt_enqueue_src_ip,
                        dst_ip: slow_path_send_pkt_enqueue_dst_ip};

    always_comb begin
        occ_next = occ;
        case ({enq_fire, deq_fire})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ_next;
        end
    end

    slow_path_send_q_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(slow_path_send_entry_struct))
    ) u_mem (
        .clk     (clk),
        .wr_en   (enq_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (slow_path_send_q_tx_entry)
    );

`ifdef SLOW_PATH_SEND_Q_STATS_EN
    // hwm tracks the post-update occupancy so it agrees with the occupancy output.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            hwm       <= '0;
        end else begin
            if (slow_path_send_pkt_enqueue_val && !slow_path_send_pkt_enqueue_rdy
                    && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (occ_next > hwm) begin
                hwm <= occ_next;
            end
        end
    end
`endif
endmodule

// File: tb/tb_tcp_slow_path_send_q.sv
// tb/tb_tcp_slow_path_send_q.sv - scoreboard bench for tcp_slow_path_send_q (DEPTH=4)
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

module tb_tcp_slow_path_send_q;
    import packet_struct_pkg::*;
    import tcp_pkg::*;
    import tcp_misc_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       enq_val = 1'b0;
    logic                       enq_rdy;
    tcp_pkt_hdr                 enq_pkt = '0;
    logic [FLOWID_W-1:0]        enq_flowid = '0;
    logic [`IP_ADDR_W-1:0]      enq_src_ip = '0;
    logic [`IP_ADDR_W-1:0]      enq_dst_ip = '0;
    logic                       tx_val;
    logic                       tx_rdy = 1'b0;
    slow_path_send_entry_struct tx_entry;
    logic [2:0]                 occupancy;
`ifdef SLOW_PATH_SEND_Q_STATS_EN
    logic [31:0]                stall_cnt;
    logic [2:0]                 hwm;
`endif

    int compared = 0;
    int mismatched = 0;
    int m_occ = 0;
    int m_stall = 0;
    int m_hwm = 0;
    slow_path_send_entry_struct exp_q[$];
    slow_path_send_entry_struct z;

    always #5 clk = ~clk;

    tcp_slow_path_send_q #(.DEPTH(4)) dut (
        .clk                               (clk),
        .rst                               (rst),
        .slow_path_send_pkt_enqueue_val    (enq_val),
        .slow_path_send_pkt_enqueue_rdy    (enq_rdy),
        .slow_path_send_pkt_enqueue_pkt    (enq_pkt),
        .slow_path_send_pkt_enqueue_flowid (enq_flowid),
        .slow_path_send_pkt_enqueue_src_ip (enq_src_ip),
        .slow_path_send_pkt_enqueue_dst_ip (enq_dst_ip),
        .slow_path_send_q_tx_val           (tx_val),
        .tx_slow_path_send_q_rdy           (tx_rdy),
        .slow_path_send_q_tx_entry         (tx_entry),
        .slow_path_send_q_occupancy        (occupancy)
`ifdef SLOW_PATH_SEND_Q_STATS_EN
        ,
        .stall_cnt                         (stall_cnt),
        .hwm                               (hwm)
`endif
    );

    function automatic slow_path_send_entry_struct mk(input logic [7:0] fid,
                                                      input logic [31:0] seq,
                                                      input logic [7:0] fl);
        slow_path_send_entry_struct e;
        e.pkt.src_port = 16'd80;
        e.pkt.dst_port = {8'h10, fid};
        e.pkt.seq_num  = seq;
        e.pkt.ack_num  = {24'hA00000, fid};
        e.pkt.flags    = fl;
        e.pkt.window   = 16'hFFFF;
        e.flowid       = fid;
        e.src_ip       = 32'h0A00_0001;
        e.dst_ip       = {24'hC0A800, fid};
        return e;
    endfunction

    function automatic slow_path_send_entry_struct mkf(input logic [7:0] fid);
        return mk(fid, {8'h5A, 16'h0000, fid}, 8'h18);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the bench model predicts fires, occupancy and stats.
    task automatic step(input logic r, input logic ev,
                        input slow_path_send_entry_struct e, input logic tr);
        int nocc;
        rst        = r;
        enq_val    = ev;
        enq_pkt    = e.pkt;
        enq_flowid = e.flowid;
        enq_src_ip = e.src_ip;
        enq_dst_ip = e.dst_ip;
        tx_rdy     = tr;
        if (!r) begin
            chk("enq_rdy", enq_rdy, m_occ < 4);
            chk("tx_val", tx_val, m_occ != 0);
            chk("occupancy", occupancy, m_occ);
`ifdef SLOW_PATH_SEND_Q_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("hwm", hwm, m_hwm);
`endif
        end
        nocc = m_occ;
        if (r) begin
            nocc = 0;
            m_stall = 0;
            m_hwm = 0;
            exp_q.delete();
        end else begin
            if (ev && m_occ == 4) m_stall++;
            if (ev && m_occ < 4) begin
                exp_q.push_back(e);
                nocc++;
            end
            if (tr && m_occ != 0) nocc--;
            if (nocc > m_hwm) m_hwm = nocc;
        end
        @(posedge clk);
        #1;
        m_occ = nocc;
    endtask

    always @(negedge clk) begin
        if (!rst && tx_val) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL head_unexpected: got flowid 0x%0h expected no entry at %0t",
                         tx_entry.flowid, $time);
            end else begin
                if (tx_entry !== exp_q[0]) begin
                    mismatched++;
                    $display("FAIL head_entry: got flowid 0x%0h seq 0x%0h expected flowid 0x%0h seq 0x%0h at %0t",
                             tx_entry.flowid, tx_entry.pkt.seq_num,
                             exp_q[0].flowid, exp_q[0].pkt.seq_num, $time);
                end
                if (tx_rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        z = mkf(8'h00);
        step(1'b1, 1'b0, z, 1'b0);
        step(1'b1, 1'b0, z, 1'b0);
        chk("reset_tx_val", tx_val, 1'b0);
        chk("reset_enq_rdy", enq_rdy, 1'b1);
        chk("reset_occ", occupancy, 3'd0);

        // Single SYN-ACK: visible next cycle, occupancy 0->1->0
        step(1'b0, 1'b1, mk(8'd3, 32'h0000_00FF, 8'h12), 1'b0);
        chk("single_occ1", occupancy, 3'd1);
        step(1'b0, 1'b0, z, 1'b1);
        chk("single_occ0", occupancy, 3'd0);

        // Fill past DEPTH with consumer stalled
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, mkf(8'(i)), 1'b0);
        chk("full_occ", occupancy, 3'd4);
        chk("full_rdy", enq_rdy, 1'b0);

        // One dequeue while enqueue of flowid 4 is held
        step(1'b0, 1'b1, mkf(8'd4), 1'b1);
        chk("deq_occ3", occupancy, 3'd3);
        step(1'b0, 1'b1, mkf(8'd4), 1'b0);
        chk("refill_occ4", occupancy, 3'd4);
        repeat (5) step(1'b0, 1'b0, z, 1'b1);

        // Steady state at occupancy 2 across pointer wrap
        step(1'b0, 1'b1, mkf(8'd10), 1'b0);
        step(1'b0, 1'b1, mkf(8'd11), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, mkf(8'(12 + i)), 1'b1);
        chk("steady_occ2", occupancy, 3'd2);
        repeat (3) step(1'b0, 1'b0, z, 1'b1);

        // Reset with three entries queued; enqueue and dequeue in reset cycle ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mkf(8'(20 + i)), 1'b0);
        step(1'b1, 1'b1, mkf(8'd23), 1'b1);
        chk("midrst_tx_val", tx_val, 1'b0);
        chk("midrst_occ", occupancy, 3'd0);
        chk("midrst_rdy", enq_rdy, 1'b1);
        step(1'b0, 1'b1, mkf(8'd30), 1'b0);
        repeat (3) step(1'b0, 1'b0, z, 1'b1);

`ifdef SLOW_PATH_SEND_Q_STATS_EN
        step(1'b1, 1'b0, z, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, mkf(8'(40 + i)), 1'b0);
        repeat (7) step(1'b0, 1'b1, mkf(8'd44), 1'b0);
        chk("stats_stall7", stall_cnt, 32'd7);
        chk("stats_hwm4", hwm, 3'd4);
        step(1'b1, 1'b0, z, 1'b0);
        chk("stats_rst_stall", stall_cnt, 32'd0);
        chk("stats_rst_hwm", hwm, 3'd0);
        step(1'b0, 1'b0, z, 1'b0);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
